// File: rtl/addsub_seq_ctrl.sv
// Nibble-serial multi-precision add/subtract sequencer driving one 4-bit slice LSB-first.
// Optional signed-overflow output enabled by defining ADDSUB_OVF_EN; otherwise ovf is tied low.
module addsub_seq_ctrl #(
    parameter int NIB = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [4*NIB-1:0]   op_a,
    input  logic [4*NIB-1:0]   op_b,
    input  logic               sub,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [4*NIB-1:0]   result,
    output logic               cout,
    output logic               ovf
);
    localparam int W  = 4 * NIB;
    localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nx;
    logic [W-1:0]    a_q, b_q;
    logic            sub_q;
    logic            carry;
    logic [IW-1:0]   idx;
    logic [3:0]      a_nib, b_nib;
    logic [4:0]      sum;
    logic            last;
    logic            accept;

    assign start_ready = (state == IDLE);
    assign res_valid   = (state == DONE);
    assign accept      = start_valid && (state == IDLE);

    // Slice: B is inverted for subtract and the initial carry supplies the +1.
    always_comb begin
        a_nib = 4'(a_q >> {idx, 2'b00});
        b_nib = 4'(b_q >> {idx, 2'b00}) ^ {4{sub_q}};
        sum   = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};
        last  = (idx == IW'(NIB - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_valid) state_nx = RUN;
            RUN:     if (last)        state_nx = DONE;
            DONE:    if (res_ready)   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            sub_q  <= 1'b0;
            carry  <= 1'b0;
            idx    <= '0;
            result <= '0;
            cout   <= 1'b0;
        end else if (accept) begin
            a_q    <= op_a;
            b_q    <= op_b;
            sub_q  <= sub;
            carry  <= sub;
            idx    <= '0;
            result <= '0;
            cout   <= 1'b0;
        end else if (state == RUN) begin
            result[{idx, 2'b00} +: 4] <= sum[3:0];
            carry <= sum[4];
            if (last) cout <= sum[4] ^ sub_q;
            else      idx  <= idx + 1'b1;
        end
    end

`ifdef ADDSUB_OVF_EN
    logic msb_cin;

    // Carry into bit W-1 is recovered from the top nibble's bit 3 sum.
    assign msb_cin = a_nib[3] ^ b_nib[3] ^ sum[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        ovf <= 1'b0;
        else if (accept)                ovf <= 1'b0;
        else if (state == RUN && last)  ovf <= msb_cin ^ sum[4];
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Directed scoreboard bench for addsub_seq_ctrl (NIB=4): reset, arithmetic cases,
// input sampling, backpressure, mid-operation reset and back-to-back throughput.
module tb_addsub_seq_ctrl;
    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         o;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] op_a, op_b;
    logic         sub;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    exp_t sb[$];

    addsub_seq_ctrl #(.NIB(NIB)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .sub         (sub),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .cout        (cout),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t       e;
        logic [W:0] t;
        t   = s ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        e.r = t[W-1:0];
        e.c = t[W];
`ifdef ADDSUB_OVF_EN
        e.o = s ? ((a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]))
                : ((a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]));
`else
        e.o = 1'b0;
`endif
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_result"}, 32'(result), 32'(e.r));
            check({tag, "_cout"},   32'(cout),   32'(e.c));
            check({tag, "_ovf"},    32'(ovf),    32'(e.o));
        end
    endtask

    // Accepts one op, scrambles the inputs after acceptance, checks latency and result.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int n;
        sb.push_back(model(a, b, s));
        op_a = a; op_b = b; sub = s; start_valid = 1'b1; res_ready = 1'b0;
        n = 0;
        while (!start_ready && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        check({tag, "_accepted"}, 32'(start_ready), 32'd0);
        start_valid = 1'b0; op_a = ~a; op_b = ~b; sub = ~s;
        n = 0;
        while (!res_valid && n < 20) begin @(posedge clk); #1; n++; end
        check({tag, "_latency"}, 32'(n), 32'(NIB));
        check_result(tag);
    endtask

    task automatic finish_op(input string tag);
        res_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_rv_drop"}, 32'(res_valid),   32'd0);
        check({tag, "_sr_rise"}, 32'(start_ready), 32'd1);
        res_ready = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_start_ready"}, 32'(start_ready), 32'd1);
        check({tag, "_res_valid"},   32'(res_valid),   32'd0);
        check({tag, "_result"},      32'(result),      32'd0);
        check({tag, "_cout"},        32'(cout),        32'd0);
        check({tag, "_ovf"},         32'(ovf),         32'd0);
    endtask

    initial begin
        int           n;
        int           t_acc;
        int           t_prev;
        logic [W-1:0] ra, rb;
        logic         rs;

        rst = 1'b1; start_valid = 1'b0; res_ready = 1'b0;
        op_a = '0; op_b = '0; sub = 1'b0;
        t_prev = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        run_op("add_basic", 16'h1234, 16'h0FFF, 1'b0);  finish_op("add_basic");
        run_op("add_wrap",  16'hFFFF, 16'h0001, 1'b0);  finish_op("add_wrap");
        run_op("sub_borrow",16'h0005, 16'h0007, 1'b1);  finish_op("sub_borrow");
        run_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0);  finish_op("add_ovf");
        run_op("sub_ovf",   16'h8000, 16'h0001, 1'b1);  finish_op("sub_ovf");

        // Backpressure: result held, new requests ignored while DONE.
        run_op("bp", 16'h00AA, 16'h0055, 1'b0);
        start_valid = 1'b1; op_a = 16'h1111; op_b = 16'h2222; sub = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_result",      32'(result),      32'h00FF);
            check("bp_res_valid",   32'(res_valid),   32'd1);
            check("bp_start_ready", 32'(start_ready), 32'd0);
        end
        start_valid = 1'b0;
        finish_op("bp");
        run_op("after_bp", 16'h0100, 16'h0001, 1'b1);  finish_op("after_bp");

        // Reset during the second RUN cycle discards the operation.
        sb.push_back(model(16'hABCD, 16'h1111, 1'b0));
        op_a = 16'hABCD; op_b = 16'h1111; sub = 1'b0; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_reset_vals("midrst");
        void'(sb.pop_front());
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        run_op("post_rst", 16'h0001, 16'h0001, 1'b0);  finish_op("post_rst");

        // Back-to-back with both handshakes held high.
        res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
            sb.push_back(model(ra, rb, rs));
            op_a = ra; op_b = rb; sub = rs; start_valid = 1'b1;
            n = 0;
            do begin @(posedge clk); #1; n++; end while (start_ready && n < 20);
            check("b2b_accept", 32'(start_ready), 32'd0);
            t_acc = cyc;
            if (i > 0) check("b2b_period", 32'(t_acc - t_prev), 32'(NIB + 2));
            t_prev = t_acc;
            n = 0;
            while (!res_valid && n < 20) begin @(posedge clk); #1; n++; end
            check("b2b_latency", 32'(n), 32'(NIB));
            check_result("b2b");
        end
        start_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b_idle", 32'(start_ready), 32'd1);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
